seq_monitor: RTL
================

// Module: seq_monitor
// PURPOSE
//  Downstream checker for the 2-bit state_mach output y. Samples the code stream,
//  locks onto the legal cycle 00->01->10->00, and counts completed periods.
//  Flags illegal codes/transitions with a sticky error for the bench or status logic.
//  Sits directly after state_mach; consumes y, produces status only (no back-pressure).
// PARAMETERS
//  CNT_W        8  width of period counter
//  LOCK_PERIODS 2  consecutive clean periods required before LOCKED (>=1)
//  SATURATE     0  1: period_cnt holds at max; 0: wraps to 0
// PORTS
//  clk         in   1      single clock, all state on rising edge
//  rst         in   1      synchronous, active-high reset
//  y_in        in   2      state code from state_mach
//  valid_in    in   1      sample enable; y_in ignored when 0
//  clear       in   1      sync clear of error/counters, returns to UNLOCKED
//  locked      out  1      1 while FSM in LOCKED
//  wrap_pulse  out  1      one-cycle pulse per completed period (10->00) in LOCKED
//  period_cnt  out  CNT_W  completed periods since lock/clear
//  err         out  1      sticky; 1 while FSM in FAULT
//  err_code    out  2      00 none, 01 illegal code 11, 10 illegal transition
// BEHAVIOUR
//  - Reset: FSM=UNLOCKED, prev_valid=0, locked=0, wrap_pulse=0, period_cnt=0,
//    err=0, err_code=00, lock_cnt=0. All outputs registered; latency 1 clk from sample.
//  - Step legality (prev->cur): hold (cur==prev) legal; advance 00->01, 01->10,
//    10->00 legal; any other pair illegal; cur==11 is illegal code (priority over transition).
//  - Only cycles with valid_in=1 are samples; first sample after reset/clear loads
//    prev only (prev_valid<=1), no check.
//  - UNLOCKED: legal 10->00 increments lock_cnt; any illegal step/code clears lock_cnt,
//    no error raised. lock_cnt reaching LOCK_PERIODS -> LOCKED, period_cnt=0.
//  - LOCKED: 10->00 -> wrap_pulse=1 next cycle, period_cnt+1 (wrap at 2^CNT_W-1
//    to 0, or hold if SATURATE=1). Illegal code -> FAULT, err_code=01; illegal
//    transition -> FAULT, err_code=10; locked drops same edge err rises.
//  - FAULT: err=1, err_code and period_cnt frozen; samples ignored; exit only via clear/rst.
//  - clear: next state UNLOCKED, prev_valid=0, lock_cnt=0, period_cnt=0, err=0,
//    err_code=00, wrap_pulse=0. clear with valid_in same cycle: clear wins, sample dropped.
//  - rst mid-operation: identical to reset values regardless of state; rst > clear.
//  - wrap_pulse is never high for two consecutive cycles (needs >=1 sample between).
// STRUCTURE
//  - Package seq_mon_pkg: typedef enum logic[1:0] {UNLOCKED, LOCKED, FAULT} mon_state_t;
//    code constants S0=2'b00, S1=2'b01, S2=2'b10, S_ILL=2'b11; err constants
//    ERR_NONE=2'b00, ERR_CODE=2'b01, ERR_TRANS=2'b10.
//  - Sub-module seq_step_check (combinational): prev, cur -> legal, is_wrap, bad_code.
//  - Top: FSM, prev register, lock_cnt ($clog2(LOCK_PERIODS+1) bits), period counter.
// TESTING
//  1. rst=1 2 clks, release; check locked=0, err=0, period_cnt=0, err_code=00.
//  2. valid=1, y=00,01,10 x3 periods -> locked=1 after 2nd 10->00; wrap_pulse on 3rd;
//     period_cnt=1.
//  3. Locked, drive 00->10 -> err=1, err_code=10, locked=0; further samples: no change.
//  4. Locked, drive y=11 -> err_code=01; then clear=1 with valid=1 -> all zero,
//     UNLOCKED; next 00 sample only loads prev.
//  5. CNT_W=2, SATURATE=0: 5 periods after lock -> period_cnt 1,2,3,0,1; SATURATE=1
//     -> 1,2,3,3,3.
//  6. Hold codes (00,00,01,01,10,10,00) with valid gaps -> no error; rst mid-LOCKED
//     -> outputs zero next clk.

Source files
------------

// File: rtl/seq_mon_pkg.sv
// -----------------------------------------------------------------------------
// Package: seq_mon_pkg
// Purpose: Shared types and constants for the seq_monitor checker.
//   mon_state_t : monitor FSM states (UNLOCKED, LOCKED, FAULT)
//   S0..S_ILL   : 2-bit codes produced by state_mach
//   ERR_*       : values reported on err_code
// -----------------------------------------------------------------------------
package seq_mon_pkg;

  typedef enum logic [1:0] {
    UNLOCKED = 2'b00,
    LOCKED   = 2'b01,
    FAULT    = 2'b10
  } mon_state_t;

  // Legal cycle is S0 -> S1 -> S2 -> S0; S_ILL is never emitted by state_mach.
  localparam logic [1:0] S0    = 2'b00;
  localparam logic [1:0] S1    = 2'b01;
  localparam logic [1:0] S2    = 2'b10;
  localparam logic [1:0] S_ILL = 2'b11;

  localparam logic [1:0] ERR_NONE  = 2'b00;
  localparam logic [1:0] ERR_CODE  = 2'b01;
  localparam logic [1:0] ERR_TRANS = 2'b10;

endpackage

// File: rtl/seq_step_check.sv
// -----------------------------------------------------------------------------
// Module: seq_step_check
// Purpose: Combinational legality check of one step prev -> cur of the code
//          stream.
// Ports:
//   prev     in  2  previous accepted code
//   cur      in  2  current sampled code
//   legal    out 1  step is a hold or a legal advance, and cur is not S_ILL
//   is_wrap  out 1  step is S2 -> S0 (completes one period)
//   bad_code out 1  cur is the illegal code S_ILL
// -----------------------------------------------------------------------------
module seq_step_check
  import seq_mon_pkg::*;
(
  input  logic [1:0] prev,
  input  logic [1:0] cur,
  output logic       legal,
  output logic       is_wrap,
  output logic       bad_code
);

  logic advance;

  // NOTE: every output of an always_comb block gets a value on every path so
  // no latch is inferred.
  always_comb begin
    bad_code = (cur == S_ILL);
    is_wrap  = (prev == S2) && (cur == S0);
    advance  = ((prev == S0) && (cur == S1)) ||
               ((prev == S1) && (cur == S2)) ||
               is_wrap;
    // An illegal code is never a legal step, even as a "hold" of 11.
    legal    = !bad_code && ((cur == prev) || advance);
  end

endmodule

// File: rtl/seq_monitor.sv
// -----------------------------------------------------------------------------
// Module: seq_monitor
// Purpose: Downstream checker for the 2-bit state_mach code stream. Locks onto
//          the cycle 00->01->10->00, counts completed periods while locked and
//          raises a sticky error on an illegal code or transition.
// Ports:
//   clk        in  1      rising-edge clock
//   rst        in  1      synchronous active-high reset (dominates clear)
//   y_in       in  2      code from state_mach
//   valid_in   in  1      sample enable
//   clear      in  1      synchronous clear back to UNLOCKED (wins over a sample)
//   locked     out 1      monitor is in LOCKED
//   wrap_pulse out 1      one-cycle pulse per completed period while locked
//   period_cnt out CNT_W  completed periods since lock
//   err        out 1      monitor is in FAULT
//   err_code   out 2      ERR_NONE / ERR_CODE / ERR_TRANS
// -----------------------------------------------------------------------------
module seq_monitor
  import seq_mon_pkg::*;
#(
  parameter int CNT_W        = 8,
  parameter int LOCK_PERIODS = 2,
  parameter bit SATURATE     = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       y_in,
  input  logic             valid_in,
  input  logic             clear,
  output logic             locked,
  output logic             wrap_pulse,
  output logic [CNT_W-1:0] period_cnt,
  output logic             err,
  output logic [1:0]       err_code
);

  localparam int LW = $clog2(LOCK_PERIODS + 1);

  mon_state_t       state;
  logic [1:0]       prev;
  logic             prev_valid;
  logic [LW-1:0]    lock_cnt;

  logic             legal;
  logic             is_wrap;
  logic             bad_code;
  logic             sample;
  logic             check;
  logic [CNT_W-1:0] period_next;

  seq_step_check u_step (
    .prev     (prev),
    .cur      (y_in),
    .legal    (legal),
    .is_wrap  (is_wrap),
    .bad_code (bad_code)
  );

  // FAULT ignores the stream entirely; the first sample after reset/clear only
  // primes prev, so only later samples are judged.
  assign sample = valid_in && (state != FAULT);
  assign check  = sample && prev_valid;

  assign period_next = (SATURATE && (period_cnt == {CNT_W{1'b1}})) ?
                       period_cnt : period_cnt + 1'b1;

  // NOTE: all state below is updated with non-blocking assignments so every
  // register sees the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      state      <= UNLOCKED;
      prev       <= S0;
      prev_valid <= 1'b0;
      lock_cnt   <= '0;
      period_cnt <= '0;
      wrap_pulse <= 1'b0;
      err_code   <= ERR_NONE;
    end else begin
      wrap_pulse <= 1'b0;
      if (sample) begin
        prev       <= y_in;
        prev_valid <= 1'b1;
      end
      if (check) begin
        case (state)
          UNLOCKED: begin
            // Any bad step restarts the count of consecutive clean periods.
            if (!legal) begin
              lock_cnt <= '0;
            end else if (is_wrap) begin
              if (int'(lock_cnt) + 1 >= LOCK_PERIODS) begin
                state      <= LOCKED;
                lock_cnt   <= '0;
                period_cnt <= '0;
              end else begin
                lock_cnt <= lock_cnt + 1'b1;
              end
            end
          end
          LOCKED: begin
            if (bad_code) begin
              state    <= FAULT;
              err_code <= ERR_CODE;
            end else if (!legal) begin
              state    <= FAULT;
              err_code <= ERR_TRANS;
            end else if (is_wrap) begin
              wrap_pulse <= 1'b1;
              period_cnt <= period_next;
            end
          end
          default: ; // FAULT: frozen until clear or rst
        endcase
      end
    end
  end

  assign locked = (state == LOCKED);
  assign err    = (state == FAULT);

endmodule
